// File: rtl/mul8_seq_pkg.sv
// Shared types and helpers for the nibble-serial 8x8 multiplier sequencer.
// Quadrant codes double as the sub_sel value exported to the external 4x4 core.
package mul8_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LL,
      ST_LH,
      ST_HL,
      ST_HH,
      ST_DONE
   } state_t;

   localparam logic [1:0] QUAD_LL = 2'd0;
   localparam logic [1:0] QUAD_LH = 2'd1;
   localparam logic [1:0] QUAD_HL = 2'd2;
   localparam logic [1:0] QUAD_HH = 2'd3;

   localparam logic [3:0] SHIFT_LL = 4'd0;
   localparam logic [3:0] SHIFT_LH = 4'd4;
   localparam logic [3:0] SHIFT_HL = 4'd4;
   localparam logic [3:0] SHIFT_HH = 4'd8;

   function automatic logic [3:0] quad_shift(input logic [1:0] q);
      case (q)
         QUAD_LL: return SHIFT_LL;
         QUAD_LH: return SHIFT_LH;
         QUAD_HL: return SHIFT_HL;
         default: return SHIFT_HH;
      endcase
   endfunction

   // Bit q of sel picks the high nibble: bit 1 for the a side, bit 0 for the b side.
   function automatic logic [3:0] nib_a(input logic [1:0] q, input logic [7:0] a);
      return q[1] ? a[7:4] : a[3:0];
   endfunction

   function automatic logic [3:0] nib_b(input logic [1:0] q, input logic [7:0] b);
      return q[0] ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [3:0] skip_mask(input logic [7:0] a, input logic [7:0] b,
                                            input logic en);
      logic [3:0] m;
      for (int i = 0; i < 4; i++)
         m[i] = (nib_a(i[1:0], a) == 4'h0) || (nib_b(i[1:0], b) == 4'h0);
      return en ? m : 4'b0000;
   endfunction

   // Returns {found, quad}: the first non-skipped quadrant at or after 'from'.
   function automatic logic [2:0] next_quad(input logic [2:0] from, input logic [3:0] skip);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--)
         if (i >= int'(from) && !skip[i])
            r = {1'b1, i[1:0]};
      return r;
   endfunction

   function automatic state_t quad_state(input logic [1:0] q);
      case (q)
         QUAD_LL: return ST_LL;
         QUAD_LH: return ST_LH;
         QUAD_HL: return ST_HL;
         default: return ST_HH;
      endcase
   endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand and result valid/ready streams of the sequenced multiplier.
interface mul8_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] prod;

   modport master (output in_valid, a, b, out_ready,
                   input  in_ready, out_valid, prod);
   modport slave  (input  in_valid, a, b, out_ready,
                   output in_ready, out_valid, prod);
endinterface

// File: rtl/mul8_seq_ctrl_pp_accum.sv
// Partial-product accumulator: shifts the core result by quadrant weight and
// adds it into a 16-bit register that wraps modulo 2^16.
module pp_accum
   import mul8_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [1:0]  sel,
   input  logic [7:0]  sub_prod,
   output logic [15:0] acc
);

   logic [15:0] term;

   always_comb begin
      term = {8'h00, sub_prod} << quad_shift(sel);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= 16'h0000;
      else if (clr)
         acc <= 16'h0000;
      else if (en)
         acc <= acc + term;
   end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 unsigned multiply sequenced over one shared external 4x4 core,
// one nibble quadrant per cycle in the order LL, LH, HL, HH.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// LL    | core fed a[3:0] x b[3:0], weight 1
// LH    | core fed a[3:0] x b[7:4], weight 16
// HL    | core fed a[7:4] x b[3:0], weight 16
// HH    | core fed a[7:4] x b[7:4], weight 256
// DONE  | out_valid high, prod held until out_ready
module mul8_seq_ctrl
   import mul8_seq_pkg::*;
#(
   parameter bit ZERO_SKIP = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mul8_seq_ctrl_if.slave        bus,
   output logic [3:0]            sub_a,
   output logic [3:0]            sub_b,
   output logic [1:0]            sub_sel,
   output logic                  sub_active,
   input  logic [7:0]            sub_prod
);

   state_t      state;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [3:0]  skip_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic [15:0] acc;

   logic [3:0]  acc_skip;
   logic [2:0]  go_q;
   logic [7:0]  go_a;
   logic [7:0]  go_b;
   logic        accept;

   assign accept        = (state == ST_IDLE) && bus.in_valid;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.prod      = acc;

   // In IDLE the skip mask comes straight from the incoming operands so the
   // first live quadrant is entered on the accept edge with no extra cycle.
   always_comb begin
      acc_skip = skip_mask(bus.a, bus.b, ZERO_SKIP);
      if (state == ST_IDLE) begin
         go_q = next_quad(3'd0, acc_skip);
         go_a = bus.a;
         go_b = bus.b;
      end else begin
         go_q = next_quad({1'b0, sub_sel} + 3'd1, skip_q);
         go_a = a_q;
         go_b = b_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         skip_q      <= 4'h0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sub_a       <= 4'h0;
         sub_b       <= 4'h0;
         sub_sel     <= 2'd0;
         sub_active  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_LL, ST_LH, ST_HL, ST_HH: begin
               if (state != ST_IDLE || bus.in_valid) begin
                  if (state == ST_IDLE) begin
                     a_q        <= bus.a;
                     b_q        <= bus.b;
                     skip_q     <= acc_skip;
                     in_ready_q <= 1'b0;
                  end
                  if (go_q[2]) begin
                     state      <= quad_state(go_q[1:0]);
                     sub_active <= 1'b1;
                     sub_sel    <= go_q[1:0];
                     sub_a      <= nib_a(go_q[1:0], go_a);
                     sub_b      <= nib_b(go_q[1:0], go_b);
                  end else begin
                     state       <= ST_DONE;
                     out_valid_q <= 1'b1;
                     sub_active  <= 1'b0;
                     sub_sel     <= 2'd0;
                     sub_a       <= 4'h0;
                     sub_b       <= 4'h0;
                  end
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               sub_active  <= 1'b0;
            end
         endcase
      end
   end

   pp_accum u_pp_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .en       (sub_active),
      .sel      (sub_sel),
      .sub_prod (sub_prod),
      .acc      (acc)
   );

endmodule
